run_ctrl: RTL

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 14 +
 rtl/debounce.sv | 50 +++++
 rtl/run_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared run-state encoding and default timing constants for the run/step controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } run_state_t;

  localparam int unsigned DB_LIMIT_DEFAULT = 1000000;  // 10 ms at 100 MHz
  localparam int unsigned RUN_DIV_DEFAULT  = 20000;

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer.
// level_o follows the synced input only after it has differed for DB_LIMIT consecutive cycles.
module debounce
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DB_LIMIT = DB_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o
);

  localparam int CW = $clog2(DB_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_LIMIT - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    // Any cycle where the synced input agrees with the level restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/run_ctrl.sv
// Run/halt/single-step controller issuing one-cycle cpu_en pulses with a PC breakpoint.
// All outputs registered; a step request gives STEP+cpu_en one cycle later.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DB_LIMIT = DB_LIMIT_DEFAULT,
  parameter int unsigned RUN_DIV  = RUN_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_step,
  input  logic        sw_run,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc_current,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        halted,
  output logic [31:0] step_cnt
);

  localparam int PW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(RUN_DIV - 1);

  logic btn_lvl, run_lvl;

  debounce #(.DB_LIMIT(DB_LIMIT)) u_db_step (
    .clk    (clk),
    .rst    (rst),
    .din_i  (btn_step),
    .level_o(btn_lvl)
  );

  debounce #(.DB_LIMIT(DB_LIMIT)) u_db_run (
    .clk    (clk),
    .rst    (rst),
    .din_i  (sw_run),
    .level_o(run_lvl)
  );

  run_state_t    state_q, state_d;
  logic          cpu_en_q, cpu_en_d;
  logic          halted_q, halted_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   step_cnt_q, step_cnt_d;
  logic          btn_prev_q, step_req_q;
  logic          armed_q, armed_d;
  logic          slot, bp_hit;

  assign slot   = (presc_q == PRESC_LAST);
  assign bp_hit = bp_en && (pc_current == bp_addr);

  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    presc_d  = '0;
    // RUN may only be (re)entered after the switch has been seen low since the last breakpoint.
    armed_d  = armed_q | ~run_lvl;
    case (state_q)
      HALT: begin
        if (run_lvl && armed_q) begin
          state_d = RUN;
        end else if (step_req_q) begin
          state_d  = STEP;
          cpu_en_d = 1'b1;
        end
      end
      RUN: begin
        if (slot && bp_hit) begin
          state_d = BREAK;
          armed_d = 1'b0;
        end else if (!run_lvl) begin
          state_d = HALT;
        end else begin
          cpu_en_d = slot;
          presc_d  = slot ? '0 : presc_q + PW'(1);
        end
      end
      STEP: begin
        state_d = HALT;
      end
      BREAK: begin
        if (!run_lvl) begin
          state_d = HALT;
        end else if (step_req_q) begin
          state_d  = STEP;
          cpu_en_d = 1'b1;
        end
      end
      default: state_d = HALT;
    endcase
    halted_d   = (state_d == HALT) || (state_d == BREAK);
    step_cnt_d = step_cnt_q + {31'b0, cpu_en_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HALT;
      cpu_en_q   <= 1'b0;
      halted_q   <= 1'b1;
      presc_q    <= '0;
      step_cnt_q <= '0;
      btn_prev_q <= 1'b0;
      step_req_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_en_q   <= cpu_en_d;
      halted_q   <= halted_d;
      presc_q    <= presc_d;
      step_cnt_q <= step_cnt_d;
      btn_prev_q <= btn_lvl;
      step_req_q <= btn_lvl & ~btn_prev_q;
      armed_q    <= armed_d;
    end
  end

  assign cpu_en   = cpu_en_q;
  assign state    = state_q;
  assign halted   = halted_q;
  assign step_cnt = step_cnt_q;

endmodule
